uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- Controller that sequences the UART receive byte stream into a program/data load for the core.
- Sits between the UART receiver (byte + one-cycle valid pulse + framing-error flag) and the instruction-memory write port; also drives the UART transmitter for a single completion acknowledge byte.
- Protocol: 4-byte little-endian word count header, then count × 4-byte little-endian words, written to consecutive addresses from 0.

Parameters:
- ADDR_WIDTH, 12, width of mem_addr; the word address space is 2**ADDR_WIDTH.
- MAX_WORDS, 4096, largest accepted header count; must be ≤ 2**ADDR_WIDTH.
- TIMEOUT_CYCLES, 50_000_000, maximum clk cycles allowed between consecutive bytes while loading; 0 disables the timeout.
- ACK_BYTE, 8'hAA, byte sent on successful completion.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse; arms a new load.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle pulse; rx_data is valid.
- rx_ferr  input  1  receiver framing error; level, sticky in the receiver.
- tx_data  output  8  byte to transmit.
- tx_start  output  1  one-cycle transmit request.
- tx_busy  input  1  transmitter busy.
- mem_we  output  1  memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address.
- mem_wdata  output  32  assembled word.
- busy  output  1  high in HDR, PAYLOAD and ACK.
- done  output  1  load completed; held until next start or reset.
- err  output  2  0 none, 1 framing, 2 length, 3 timeout; held until next start or reset.
- word_count  output  ADDR_WIDTH+1  words written in the current or last load.

Behaviour:
- Reset: state IDLE. All of the following are 0: tx_data, tx_start, mem_we, mem_addr, mem_wdata, busy, done, err, word_count. Byte index, header register and timeout counter are also cleared.
- States: IDLE, HDR, PAYLOAD, ACK, DONE, ERROR.
- IDLE: rx_valid is ignored. start → HDR, with done/err/word_count/byte index/timeout cleared.
- HDR:
  - Each rx_valid shifts rx_data into header byte [idx], LSB first, and idx increments mod 4.
  - On the 4th byte, the cycle after: count > MAX_WORDS → ERROR with err=2; count == 0 → ACK; else → PAYLOAD.
- PAYLOAD:
  - Bytes assemble LSB first into a 32-bit word.
  - The cycle after the 4th byte's rx_valid: mem_we=1 for exactly one cycle, mem_wdata=word, mem_addr=word_count[ADDR_WIDTH-1:0]; word_count increments in the same cycle.
  - When the incremented word_count equals the header count → ACK.
- ACK:
  - Wait while tx_busy=1.
  - First cycle with tx_busy=0: tx_start=1 for one cycle, tx_data=ACK_BYTE, then → DONE.
- DONE: done=1. start → HDR (re-arm). rx_valid is ignored.
- ERROR: err held, busy=0, no further mem_we or tx_start. start → HDR only if rx_ferr=0; otherwise stay in ERROR.
- Framing error: rx_ferr=1 in any cycle while in HDR or PAYLOAD → ERROR with err=1, next cycle. This takes priority over a same-cycle rx_valid; that byte is discarded.
- Timeout:
  - Counter runs in HDR/PAYLOAD and clears on each rx_valid.
  - Reaching TIMEOUT_CYCLES → ERROR with err=3.
  - A same-cycle rx_valid wins over the timeout.
- start while busy=1 is ignored.
- Reset mid-load: immediate return to IDLE; partially written memory is not rolled back.

Decomposition:
- Shared package uart_pkg holds:
  - state enum loader_state_t;
  - error code constants ERR_NONE/ERR_FRAME/ERR_LEN/ERR_TIMEOUT;
  - ACK_BYTE default;
  - shared CLK_PER_HALF_BIT.
- Natural sub-module: uart_word_assembler (byte index, LSB-first shift into 32 bits, word_ready pulse). Used for both header and payload.

Test Plan:
- Header 02 00 00 00, payload 78 56 34 12 EF BE AD DE, tx_busy=0 → mem writes (0, 0x12345678) then (1, 0xDEADBEEF), each one cycle wide; tx_start with 0xAA; done=1, word_count=2, err=0.
- Header 00 00 00 00 with tx_busy held 1 for 100 cycles → no mem_we; tx_start exactly 1 cycle after tx_busy falls; done=1.
- Header 01 10 00 00 (count 4097 > MAX_WORDS) → err=2, no mem_we, no tx_start, busy=0.
- rx_ferr=1 after 2 payload bytes, coincident with an rx_valid → err=1 next cycle; no write for the partial word; start ignored until rx_ferr=0.
- TIMEOUT_CYCLES=1000: 1 header byte, then silence → err=3 exactly 1000 cycles after the last rx_valid. Repeat with a byte at cycle 999 → no error.
- rx_valid bytes in IDLE, plus start while busy, then rstn low mid-payload → no state change from the IDLE bytes or the extra start; after reset, all outputs 0 and state IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART program loader.
// Contents: loader state encoding, error codes, default acknowledge byte,
// datapath widths and the UART bit-timing constant shared with the rx/tx blocks.
package uart_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned ERR_W  = 2;

   // Clocks per half UART bit, shared by the receiver and transmitter.
   localparam int unsigned CLK_PER_HALF_BIT = 217;

   localparam logic [BYTE_W-1:0] ACK_BYTE_DEF = 8'hAA;

   localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
   localparam logic [ERR_W-1:0] ERR_FRAME   = 2'd1;
   localparam logic [ERR_W-1:0] ERR_LEN     = 2'd2;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_ACK     = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERROR   = 3'd5
   } loader_state_t;

endpackage

// File: rtl/uart_loader_if.sv
// Loader bus: UART rx/tx side, instruction-memory write port, status.
// slave  : the loader (consumes start/rx/tx_busy, drives memory, tx and status)
// master : the environment around the loader
interface uart_loader_if
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12
);
   logic                  start;
   logic [BYTE_W-1:0]     rx_data;
   logic                  rx_valid;
   logic                  rx_ferr;
   logic [BYTE_W-1:0]     tx_data;
   logic                  tx_start;
   logic                  tx_busy;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_W-1:0]     mem_wdata;
   logic                  busy;
   logic                  done;
   logic [ERR_W-1:0]      err;
   logic [ADDR_WIDTH:0]   word_count;

   modport slave (
      input  start, rx_data, rx_valid, rx_ferr, tx_busy,
      output tx_data, tx_start, mem_we, mem_addr, mem_wdata,
             busy, done, err, word_count
   );

   modport master (
      output start, rx_data, rx_valid, rx_ferr, tx_busy,
      input  tx_data, tx_start, mem_we, mem_addr, mem_wdata,
             busy, done, err, word_count
   );
endinterface

// File: rtl/uart_word_assembler.sv
// Assembles four received bytes, LSB first, into a 32-bit word.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   i_clear          restart at byte 0 with an empty word
//   i_valid, i_data  accepted byte
//   o_word_c         word including the byte currently presented
//   o_word_ready_c   high while the 4th byte of a word is presented
module uart_word_assembler
   import uart_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_clear,
   input  logic              i_valid,
   input  logic [BYTE_W-1:0] i_data,
   output logic [WORD_W-1:0] o_word_c,
   output logic              o_word_ready_c
);

   logic [1:0]        r_idx;
   logic [WORD_W-1:0] r_word;

   // Merge the incoming byte into its lane so the owner can act in the same cycle.
   always_comb begin
      o_word_c = r_word;
      o_word_c[{r_idx, 3'b000} +: BYTE_W] = i_data;
      o_word_ready_c = i_valid && (r_idx == 2'd3);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_idx  <= 2'd0;
         r_word <= '0;
      end else if (i_clear) begin
         r_idx  <= 2'd0;
         r_word <= '0;
      end else if (i_valid) begin
         r_word <= o_word_c;
         r_idx  <= r_idx + 2'd1;
      end
   end

endmodule

// File: rtl/uart_loader.sv
// Sequences the UART byte stream into an instruction-memory load:
// 4-byte LE word count, then count LE words written from address 0,
// then one acknowledge byte on the transmitter.
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   bus        uart_loader_if.slave: start, rx byte/valid/ferr, tx byte/start/busy,
//              mem_we/addr/wdata, busy, done, err, word_count
module uart_loader
   import uart_pkg::*;
#(
   parameter int unsigned       ADDR_WIDTH     = 12,
   parameter int unsigned       MAX_WORDS      = 4096,
   parameter int unsigned       TIMEOUT_CYCLES = 50_000_000,
   parameter logic [BYTE_W-1:0] ACK_BYTE       = ACK_BYTE_DEF
) (
   input  logic         clk,
   input  logic         rstn,
   uart_loader_if.slave bus
);

   localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
   localparam int unsigned TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

   loader_state_t         r_state;
   logic [BYTE_W-1:0]     r_tx_data;
   logic                  r_tx_start;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [WORD_W-1:0]     r_mem_wdata;
   logic                  r_busy;
   logic                  r_done;
   logic [ERR_W-1:0]      r_err;
   logic [CNT_W-1:0]      r_word_count;
   logic [CNT_W-1:0]      r_hdr_count;
   logic [TO_W-1:0]       r_to_cnt;

   logic                  w_in_load;
   logic                  w_accept;
   logic                  w_arm;
   logic                  w_timeout;
   logic [WORD_W-1:0]     w_word;
   logic                  w_word_ready;
   logic [CNT_W-1:0]      w_count_inc;

   // A framing error blocks byte acceptance; that byte is dropped.
   assign w_in_load   = (r_state == ST_HDR) || (r_state == ST_PAYLOAD);
   assign w_accept    = w_in_load && bus.rx_valid && !bus.rx_ferr;
   assign w_arm       = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                      ((r_state == ST_ERROR) && !bus.rx_ferr));
   // Counter value before the edge equals cycles since the last byte minus one.
   assign w_timeout   = TO_EN && (r_to_cnt == TO_W'(TO_LIMIT));
   assign w_count_inc = r_word_count + CNT_W'(1);

   uart_word_assembler u_asm (
      .clk            (clk),
      .rstn           (rstn),
      .i_clear        (w_arm),
      .i_valid        (w_accept),
      .i_data         (bus.rx_data),
      .o_word_c       (w_word),
      .o_word_ready_c (w_word_ready)
   );

   // Loader FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_tx_data    <= '0;
         r_tx_start   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= ERR_NONE;
         r_word_count <= '0;
         r_hdr_count  <= '0;
         r_to_cnt     <= '0;
      end else begin
         r_mem_we   <= 1'b0;
         r_tx_start <= 1'b0;

         if (w_in_load) begin
            if (w_accept)
               r_to_cnt <= '0;
            else if (TO_EN)
               r_to_cnt <= r_to_cnt + TO_W'(1);
         end

         if (w_arm) begin
            r_state      <= ST_HDR;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= ERR_NONE;
            r_word_count <= '0;
            r_to_cnt     <= '0;
         end else begin
            case (r_state)
               ST_HDR, ST_PAYLOAD: begin
                  if (bus.rx_ferr) begin
                     r_state <= ST_ERROR;
                     r_err   <= ERR_FRAME;
                     r_busy  <= 1'b0;
                  end else if (w_word_ready) begin
                     if (r_state == ST_HDR) begin
                        if (w_word > WORD_W'(MAX_WORDS)) begin
                           r_state <= ST_ERROR;
                           r_err   <= ERR_LEN;
                           r_busy  <= 1'b0;
                        end else if (w_word == '0) begin
                           r_state <= ST_ACK;
                        end else begin
                           r_state     <= ST_PAYLOAD;
                           r_hdr_count <= CNT_W'(w_word);
                        end
                     end else begin
                        r_mem_we     <= 1'b1;
                        r_mem_wdata  <= w_word;
                        r_mem_addr   <= r_word_count[ADDR_WIDTH-1:0];
                        r_word_count <= w_count_inc;
                        if (w_count_inc == r_hdr_count)
                           r_state <= ST_ACK;
                     end
                  end else if (!w_accept && w_timeout) begin
                     r_state <= ST_ERROR;
                     r_err   <= ERR_TIMEOUT;
                     r_busy  <= 1'b0;
                  end
               end
               ST_ACK: begin
                  if (!bus.tx_busy) begin
                     r_tx_start <= 1'b1;
                     r_tx_data  <= ACK_BYTE;
                     r_state    <= ST_DONE;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.tx_data    = r_tx_data;
   assign bus.tx_start   = r_tx_start;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.err        = r_err;
   assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: table of complete loads plus
// hand sequences for framing error, timeout and reset/ignore behaviour.
module tb_uart_loader;
   import uart_pkg::*;

   localparam int unsigned AW = 12;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   uart_loader_if #(.ADDR_WIDTH(AW)) bus ();

   uart_loader #(
      .ADDR_WIDTH     (AW),
      .MAX_WORDS      (4096),
      .TIMEOUT_CYCLES (1000),
      .ACK_BYTE       (8'hAA)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Observed transactions.
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   logic [7:0]    tx_q[$];
   int            tx_cyc = -1;
   int            dbl_we = 0;
   logic          prev_we = 1'b0;

   always @(negedge clk) begin
      if (bus.mem_we) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
         if (prev_we) dbl_we = dbl_we + 1;
      end
      prev_we = bus.mem_we;
      if (bus.tx_start) begin
         tx_q.push_back(bus.tx_data);
         tx_cyc = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      step();
      bus.rx_valid = 1'b0;
      step();
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
      step();
   endtask

   task automatic clear_obs();
      wr_addr.delete();
      wr_data.delete();
      tx_q.delete();
      tx_cyc = -1;
      dbl_we = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tx_data"},    bus.tx_data, 0);
      check({tag, "_tx_start"},   bus.tx_start, 0);
      check({tag, "_mem_we"},     bus.mem_we, 0);
      check({tag, "_mem_addr"},   bus.mem_addr, 0);
      check({tag, "_mem_wdata"},  bus.mem_wdata, 0);
      check({tag, "_busy"},       bus.busy, 0);
      check({tag, "_done"},       bus.done, 0);
      check({tag, "_err"},        bus.err, 0);
      check({tag, "_word_count"}, bus.word_count, 0);
      check({tag, "_state"},      dut.r_state, ST_IDLE);
   endtask

   typedef struct {
      string      name;
      int         nb;
      logic [7:0] b [16];
      int         busy_cyc;
      logic [1:0] e_err;
      logic       e_done;
      int         e_wc;
      int         e_tx;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_w;
      int          c0;
      int          c1;
      int          drop_cyc;

      vecs[0] = '{"two_words", 12,
                  '{8'h02,8'h00,8'h00,8'h00, 8'h78,8'h56,8'h34,8'h12,
                    8'hEF,8'hBE,8'hAD,8'hDE, 8'h00,8'h00,8'h00,8'h00},
                  0, ERR_NONE, 1'b1, 2, 1};
      vecs[1] = '{"zero_count", 4,
                  '{8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00,
                    8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00},
                  100, ERR_NONE, 1'b1, 0, 1};
      vecs[2] = '{"too_long", 4,
                  '{8'h01,8'h10,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00,
                    8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00,8'h00,8'h00},
                  0, ERR_LEN, 1'b0, 0, 0};
      vecs[3] = '{"three_words", 16,
                  '{8'h03,8'h00,8'h00,8'h00, 8'h01,8'h00,8'h00,8'h00,
                    8'hFF,8'hFF,8'hFF,8'hFF, 8'h00,8'h00,8'h00,8'h80},
                  3, ERR_NONE, 1'b1, 3, 1};

      bus.start    = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.rx_ferr  = 1'b0;
      bus.tx_busy  = 1'b0;

      // Reset state.
      step();
      step();
      check_all_zero("reset");
      rstn = 1'b1;
      step();

      // Table of complete loads.
      foreach (vecs[v]) begin
         clear_obs();
         bus.tx_busy = (vecs[v].busy_cyc > 0);
         pulse_start();
         check({vecs[v].name, "_armed"}, bus.busy, 1);
         step();
         for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i]);
         drop_cyc = -1;
         if (vecs[v].busy_cyc > 0) begin
            for (int k = 0; k < vecs[v].busy_cyc; k++) step();
            bus.tx_busy = 1'b0;
            drop_cyc = cyc;
         end
         for (int k = 0; k < 400 && bus.busy; k++) step();
         step();
         check({vecs[v].name, "_busy"},   bus.busy, 0);
         check({vecs[v].name, "_err"},    bus.err, vecs[v].e_err);
         check({vecs[v].name, "_done"},   bus.done, vecs[v].e_done);
         check({vecs[v].name, "_wc"},     bus.word_count, vecs[v].e_wc);
         check({vecs[v].name, "_nwr"},    wr_addr.size(), vecs[v].e_wc);
         check({vecs[v].name, "_ntx"},    tx_q.size(), vecs[v].e_tx);
         check({vecs[v].name, "_we_w"},   dbl_we, 0);
         for (int w = 0; w < vecs[v].e_wc && w < wr_data.size(); w++) begin
            exp_w = {vecs[v].b[4*w+7], vecs[v].b[4*w+6], vecs[v].b[4*w+5], vecs[v].b[4*w+4]};
            check($sformatf("%s_addr%0d", vecs[v].name, w), wr_addr[w], w);
            check($sformatf("%s_data%0d", vecs[v].name, w), wr_data[w], exp_w);
         end
         if (tx_q.size() > 0) check({vecs[v].name, "_txbyte"}, tx_q[0], 8'hAA);
         if (drop_cyc >= 0) check({vecs[v].name, "_txcyc"}, tx_cyc, drop_cyc + 1);
      end

      // Framing error coincident with a payload byte.
      do_reset();
      clear_obs();
      pulse_start();
      step();
      send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56);
      bus.rx_data  = 8'h34;
      bus.rx_valid = 1'b1;
      bus.rx_ferr  = 1'b1;
      step();
      bus.rx_valid = 1'b0;
      check("ferr_err", bus.err, ERR_FRAME);
      check("ferr_busy", bus.busy, 0);
      send_byte(8'h12);
      step();
      check("ferr_nwr", wr_addr.size(), 0);
      pulse_start();
      step();
      check("ferr_start_ign_err", bus.err, ERR_FRAME);
      check("ferr_start_ign_busy", bus.busy, 0);
      bus.rx_ferr = 1'b0;
      step();
      pulse_start();
      check("ferr_rearm_busy", bus.busy, 1);
      check("ferr_rearm_err", bus.err, ERR_NONE);

      // Timeout after one header byte of silence.
      do_reset();
      pulse_start();
      step();
      bus.rx_data  = 8'h05;
      bus.rx_valid = 1'b1;
      step();
      bus.rx_valid = 1'b0;
      c0 = cyc;
      for (int k = 0; k < 1100 && bus.err == ERR_NONE; k++) step();
      check("to_err", bus.err, ERR_TIMEOUT);
      check("to_cycle", cyc, c0 + 1000);
      check("to_busy", bus.busy, 0);

      // A byte on cycle 999 restarts the timeout.
      do_reset();
      pulse_start();
      step();
      bus.rx_data  = 8'h05;
      bus.rx_valid = 1'b1;
      step();
      bus.rx_valid = 1'b0;
      c0 = cyc;
      for (int k = 0; k < 998; k++) step();
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b1;
      step();
      bus.rx_valid = 1'b0;
      c1 = cyc;
      step();
      check("to999_span", c1, c0 + 999);
      check("to999_err", bus.err, ERR_NONE);
      check("to999_busy", bus.busy, 1);
      for (int k = 0; k < 1100 && bus.err == ERR_NONE; k++) step();
      check("to999_next_err", bus.err, ERR_TIMEOUT);
      check("to999_next_cycle", cyc, c1 + 1000);

      // IDLE bytes ignored, start while busy ignored, reset mid-payload.
      do_reset();
      clear_obs();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("idle_busy", bus.busy, 0);
      check("idle_state", dut.r_state, ST_IDLE);
      pulse_start();
      step();
      send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      pulse_start();
      step();
      check("busy_start_busy", bus.busy, 1);
      send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66);
      check("mid_wc", bus.word_count, 1);
      check("mid_nwr", wr_addr.size(), 1);
      if (wr_data.size() > 0) begin
         check("mid_addr", wr_addr[0], 0);
         check("mid_data", wr_data[0], 32'h44332211);
      end
      check("mid_busy", bus.busy, 1);
      rstn = 1'b0;
      step();
      check_all_zero("midrst");
      rstn = 1'b1;
      step();
      check("post_rst_nwr", wr_addr.size(), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
